add16_core: RTL and testbench



---
 rtl/add16_pkg.sv | 17 +
 rtl/add16_bit_cell.sv | 27 ++
 rtl/add16_core.sv | 118 +++++++++++
 tb/tb_add16_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/add16_pkg.sv
// add16_pkg: shared width, word type, extreme constants and the signed
// overflow helper for the add16 datapath.
package add16_pkg;

  localparam int ADD_W = 16;

  typedef logic signed [15:0] word_t;

  localparam word_t WORD_MAX = 16'sh7FFF;
  localparam word_t WORD_MIN = 16'sh8000;

  // Two same-sign operands whose sum flips sign have overflowed.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add16_bit_cell.sv
// add16_bit_cell: one ripple-carry cell. HALF=1 gives a half adder (the
// carry-in is ignored). HALF=0 gives a full adder with majority carry.
module add16_bit_cell #(
  parameter bit HALF = 1'b0
) (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic s_o,
  output logic c_o
);

  logic z_eff_s;

  // A half cell behaves as a full cell whose carry-in is forced to zero.
  always_comb begin
    z_eff_s = 1'b0;
    if (HALF) begin
      z_eff_s = 1'b0;
    end else begin
      z_eff_s = z_i;
    end
    s_o = x_i ^ y_i ^ z_eff_s;
    c_o = (x_i & y_i) | (x_i & z_eff_s) | (y_i & z_eff_s);
  end

endmodule

// File: rtl/add16_core.sv
// add16_core: registered 16-bit wrapping adder built from a ripple chain of
// add16_bit_cell instances, with a one-cycle valid strobe.
// Build option: define ADD16_CORE_FLAGS_EN to compute and register carry_o
// and ovf_o; otherwise both ports are constant 0 and have no flops.
module add16_core
  import add16_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             out_valid,
  output logic             carry_o,
  output logic             ovf_o
);

  if (WIDTH != ADD_W) begin : g_width_chk
    $error("add16_core: only WIDTH=16 is supported");
  end

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             valid_d, valid_q;

  // Each carry lives in its own generate scope so the chain is a plain
  // sequence of separate nets rather than a self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic c_s;
    if (i == 0) begin : g_lsb
      add16_bit_cell #(.HALF(1'b1)) u_cell (
        .x_i (a_i[i]),
        .y_i (b_i[i]),
        .z_i (1'b0),
        .s_o (sum_s[i]),
        .c_o (c_s)
      );
    end else begin : g_upper
      add16_bit_cell #(.HALF(1'b0)) u_cell (
        .x_i (a_i[i]),
        .y_i (b_i[i]),
        .z_i (g_bit[i-1].c_s),
        .s_o (sum_s[i]),
        .c_o (c_s)
      );
    end
  end

  // Load a new sum only on valid operands; idle cycles keep the old result
  // so unknown operands never reach the outputs.
  always_comb begin
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (in_valid) begin
      sum_d   = sum_s;
      valid_d = 1'b1;
    end else begin
      sum_d   = sum_q;
      valid_d = 1'b0;
    end
  end

  // Result and strobe registers; reset clears them without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum_o     = sum_q;
  assign out_valid = valid_q;

`ifdef ADD16_CORE_FLAGS_EN
  logic carry_d, carry_q;
  logic ovf_d, ovf_q;

  // Flags follow the same load/hold rule as the sum.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      carry_d = g_bit[WIDTH-1].c_s;
      ovf_d   = ovf_f(a_i[WIDTH-1], b_i[WIDTH-1], sum_s[WIDTH-1]);
    end else begin
      carry_d = carry_q;
      ovf_d   = ovf_q;
    end
  end

  // Flag registers, cleared by reset together with the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
`else
  logic unused_carry_s;
  assign unused_carry_s = g_bit[WIDTH-1].c_s;

  assign carry_o = 1'b0;
  assign ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_add16_core.sv
// tb_add16_core: directed and random self-checking bench for add16_core and
// its bit cell. Flag expectations follow ADD16_CORE_FLAGS_EN.
module tb_add16_core;
  import add16_pkg::*;

`ifdef ADD16_CORE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a_i, b_i;
  logic [15:0] sum_o;
  logic        out_valid, carry_o, ovf_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Stand-alone cells for truth-table checks.
  logic hx, hy, hs, hc;
  logic fx, fy, fz, fs, fc;

  add16_core #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a_i       (a_i),
    .b_i       (b_i),
    .sum_o     (sum_o),
    .out_valid (out_valid),
    .carry_o   (carry_o),
    .ovf_o     (ovf_o)
  );

  add16_bit_cell #(.HALF(1'b1)) u_half (.x_i(hx), .y_i(hy), .z_i(1'b0), .s_o(hs), .c_o(hc));
  add16_bit_cell #(.HALF(1'b0)) u_full (.x_i(fx), .y_i(fy), .z_i(fz), .s_o(fs), .c_o(fc));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = a;
    b_i      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0;
    a_i      = 16'hxxxx;
    b_i      = 16'hxxxx;
    @(posedge clk);
    #1;
  endtask

  task automatic dut_sum(input logic [15:0] a, input logic [15:0] b, output logic [15:0] s);
    drive_op(a, b);
    s = sum_o;
  endtask

  // One directed vector with hand-computed sum/carry/overflow.
  task automatic check_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] es, input logic ec, input logic eo);
    drive_op(a, b);
    check({tag, "_sum"}, 32'(sum_o), 32'(es));
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_cy"},  32'(carry_o), 32'(ec & FLAGS));
    check({tag, "_ovf"}, 32'(ovf_o), 32'(eo & FLAGS));
  endtask

  initial begin
    logic [15:0] ra, rb, rc, ab, ba, abc, bc, bca, a0, neg, inv, z1, z2, m;
    logic [16:0] wide;
    int          sa, sb, ones;
    logic        exp_ovf;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a_i      = 16'h0000;
    b_i      = 16'h0000;
    hx = 1'b0; hy = 1'b0; fx = 1'b0; fy = 1'b0; fz = 1'b0;
    #2;
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_cy",  32'(carry_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Cell truth tables, expectations from counting ones.
    for (int k = 0; k < 4; k++) begin
      hx = k[1]; hy = k[0];
      #1;
      ones = int'(hx) + int'(hy);
      check($sformatf("half_s_%0d", k), 32'(hs), 32'(ones % 2));
      check($sformatf("half_c_%0d", k), 32'(hc), 32'(ones >= 2));
    end
    for (int k = 0; k < 8; k++) begin
      fx = k[2]; fy = k[1]; fz = k[0];
      #1;
      ones = int'(fx) + int'(fy) + int'(fz);
      check($sformatf("full_s_%0d", k), 32'(fs), 32'(ones % 2));
      check($sformatf("full_c_%0d", k), 32'(fc), 32'(ones >= 2));
    end

    // Carry ripple and extremes.
    check_vec("rip_000f", 16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b0);
    check_vec("rip_00ff", 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);
    check_vec("rip_0fff", 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0);
    check_vec("rip_7fff", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    check_vec("rip_ffff", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    check_vec("ext_7f_ff", 16'h7FFF, 16'hFFFF, 16'h7FFE, 1'b1, 1'b0);
    check_vec("ext_80_01", 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b0);
    check_vec("ext_80_80", 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    check_vec("ext_aa_55", 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0);
    check_vec("ext_55_55", 16'h5555, 16'h5555, 16'hAAAA, 1'b0, 1'b1);
    check_vec("ext_7f_7f", WORD_MAX, WORD_MAX, 16'hFFFE, 1'b0, 1'b1);
    check_vec("ext_7f_80", WORD_MAX, WORD_MIN, 16'hFFFF, 1'b0, 1'b0);
    check_vec("ext_80_ff", WORD_MIN, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1);

    // Handshake 1,0,1 with held result and flags in the gap.
    check_vec("hs_first", 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1);
    drive_idle();
    check("hs_gap_vld", 32'(out_valid), 32'd0);
    check("hs_gap_sum", 32'(sum_o), 32'h7FFF);
    check("hs_gap_cy",  32'(carry_o), 32'(FLAGS));
    check("hs_gap_ovf", 32'(ovf_o), 32'(FLAGS));
    check_vec("hs_third", 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0);

    // Reset asserted between edges discards the pending operation.
    drive_op(16'h1111, 16'h2222);
    check("pre_rst_sum", 32'(sum_o), 32'h3333);
    @(negedge clk);
    in_valid = 1'b1;
    a_i      = 16'h7FFF;
    b_i      = 16'h7FFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", 32'(sum_o), 32'd0);
    check("async_rst_vld", 32'(out_valid), 32'd0);
    check("async_rst_cy",  32'(carry_o), 32'd0);
    check("async_rst_ovf", 32'(ovf_o), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_sum", 32'(sum_o), 32'd0);
    check("rst_hold_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    a_i   = 16'h0005;
    b_i   = 16'h0006;
    #1;
    check("post_rst_early_vld", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_sum", 32'(sum_o), 32'h000B);
    check("post_rst_vld", 32'(out_valid), 32'd1);

    // Random algebraic properties plus a reference model for flags.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      dut_sum(ra, rb, ab);
      m    = ra + rb;
      wide = {1'b0, ra} + {1'b0, rb};
      sa   = int'($signed(ra));
      sb   = int'($signed(rb));
      exp_ovf = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      check("rnd_model", 32'(ab), 32'(m));
      check("rnd_cy",  32'(carry_o), 32'(wide[16] & FLAGS));
      check("rnd_ovf", 32'(ovf_o), 32'(exp_ovf & FLAGS));
      dut_sum(rb, ra, ba);
      check("rnd_comm", 32'(ba), 32'(ab));
      dut_sum(ab, rc, abc);
      dut_sum(rb, rc, bc);
      dut_sum(bc, ra, bca);
      check("rnd_assoc", 32'(bca), 32'(abc));
      dut_sum(ra, 16'h0000, a0);
      check("rnd_zero", 32'(a0), 32'(ra));
      neg = -ra;
      dut_sum(ra, neg, z1);
      check("rnd_neg", 32'(z1), 32'd0);
      inv = ~ra + 16'd1;
      dut_sum(ra, inv, z2);
      check("rnd_inv", 32'(z2), 32'd0);
    end

    drive_idle();
    check("final_idle_vld", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
